// File: rtl/fifo_uart_tx.sv
// Drains a registered-read byte FIFO and serialises each word as an 8N1 UART frame.
// Every output is a flop; the read strobe is exactly one cycle per frame.
module fifo_uart_tx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned WIDTH  = 8
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic             byte_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               fifo_rd_q, fifo_rd_d;
    logic               busy_q, busy_d;
    logic               byte_done_q, byte_done_d;
    logic               bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        fifo_rd_d   = 1'b0;
        busy_d      = busy_q;
        byte_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (EN && !fifo_empty) begin
                    fifo_rd_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = StRdWait;
                end
            end
            // FIFO samples the strobe on this edge; its data is valid one cycle later.
            StRdWait: begin
                state_d = StLoad;
            end
            StLoad: begin
                shift_d = fifo_data;
                tx_d    = 1'b0;
                cnt_d   = '0;
                state_d = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d       = '0;
                    byte_done_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            fifo_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            fifo_rd_q   <= fifo_rd_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign fifo_rd   = fifo_rd_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign byte_done = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at 10 clocks/bit with a registered-read FIFO model; a scoreboard
// queue holds the bytes pushed into the FIFO and each decoded frame pops one.
module tb_fifo_uart_tx;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       EN      = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd, tx, busy, byte_done;

    // FIFO model: one-cycle registered read, pointers never reset
    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;
    logic [7:0] model_dout = '0;
    logic       force_in = 1'b0;
    logic       force_empty = 1'b0;
    logic [7:0] force_data = '0;

    assign fifo_empty = force_in ? force_empty : (wr_ptr == rd_ptr);
    assign fifo_data  = force_in ? force_data : model_dout;

    int   cyc = 0;
    int   rd_cnt = 0;
    int   bad_rd = 0;
    logic empty_q = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   last_stop = 0;
    logic [7:0] exp_q [$];

    fifo_uart_tx #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000),
        .WIDTH (8)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .EN        (EN),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .byte_done (byte_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) rd_cnt <= rd_cnt + 1;
        if (fifo_rd && empty_q) bad_rd <= bad_rd + 1;
        empty_q <= fifo_empty;
        if (fifo_rd && (wr_ptr != rd_ptr)) begin
            model_dout <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 6'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 6'd1;
        exp_q.push_back(b);
    endtask

    task automatic wait_rd(input int limit, input string tag, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge sys_clk);
            if (fifo_rd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_rd_seen"}, {31'd0, ok}, 32'd1);
    endtask

    // Checks one whole frame cycle by cycle; drop_bit >= 0 lowers EN mid data bit.
    task automatic frame(input string tag, input int lim, input bit gap_chk, input int drop_bit);
        logic       ok;
        logic [9:0] fr;
        logic [7:0] exp;
        logic [7:0] rx;
        int         bad;
        wait_rd(lim, tag, ok);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            return;
        end
        exp = exp_q.pop_front();
        if (!ok) return;
        chk({tag, "_busy_at_rd"}, {31'd0, busy}, 32'd1);
        @(negedge sys_clk);
        chk({tag, "_rd_one_cycle"}, {31'd0, fifo_rd}, 32'd0);
        fr  = {1'b1, exp, 1'b0};
        rx  = '0;
        bad = 0;
        for (int slot = 0; slot < 10; slot++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge sys_clk);
                if (slot == 0 && c == 0 && gap_chk) chk({tag, "_gap"}, cyc - last_stop, 32'd13);
                if (slot == 9 && c == 0) last_stop = cyc;
                if (drop_bit >= 0 && slot == drop_bit + 1 && c == 5) EN = 1'b0;
                if (tx !== fr[slot]) bad++;
                if (byte_done !== 1'b0 || busy !== 1'b1 || fifo_rd !== 1'b0) bad++;
                if (c == 5 && slot >= 1 && slot <= 8) rx[slot-1] = tx;
            end
        end
        chk({tag, "_frame_bad_cycles"}, bad, 32'd0);
        chk({tag, "_data"}, {24'd0, rx}, {24'd0, exp});
        @(negedge sys_clk);
        chk({tag, "_byte_done"}, {31'd0, byte_done}, 32'd1);
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
        chk({tag, "_tx_idle"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        logic ok;
        int   rc;
        int   b_rd, b_tx, b_busy, b_done;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, byte_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // Single byte
        rc = rd_cnt;
        push(8'hA5);
        EN = 1'b1;
        frame("single", 5, 1'b0, -1);
        chk("single_rd_count", rd_cnt - rc, 32'd1);

        // Burst of three, back to back
        rc = rd_cnt;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        frame("burst0", 5, 1'b0, -1);
        frame("burst1", 5, 1'b1, -1);
        frame("burst2", 5, 1'b1, -1);
        chk("burst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("burst_rd_count", rd_cnt - rc, 32'd3);

        // Enable gating
        EN = 1'b0;
        @(negedge sys_clk);
        push(8'h12);
        push(8'h34);
        EN = 1'b1;
        frame("en1", 5, 1'b0, 3);
        rc = rd_cnt;
        repeat (40) @(negedge sys_clk);
        chk("en_low_no_rd", rd_cnt - rc, 32'd0);
        chk("en_low_not_empty", {31'd0, fifo_empty}, 32'd0);
        chk("en_low_busy", {31'd0, busy}, 32'd0);
        EN = 1'b1;
        frame("en2", 2, 1'b0, -1);

        // Empty idle
        rc = rd_cnt;
        b_rd = 0; b_tx = 0; b_busy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (fifo_rd !== 1'b0) b_rd++;
            if (tx !== 1'b1) b_tx++;
            if (busy !== 1'b0) b_busy++;
        end
        chk("idle_rd", b_rd, 32'd0);
        chk("idle_tx", b_tx, 32'd0);
        chk("idle_busy", b_busy, 32'd0);
        chk("idle_rd_count", rd_cnt - rc, 32'd0);
        chk("never_rd_when_empty", bad_rd, 32'd0);

        // Reset mid-frame, asserted between clock edges during data bit 5
        push(8'hC3);
        wait_rd(5, "rstmid", ok);
        void'(exp_q.pop_front());
        repeat (65) @(negedge sys_clk);
        chk("rstmid_pre_tx", {31'd0, tx}, 32'd0);
        chk("rstmid_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_tx", {31'd0, tx}, 32'd1);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, byte_done}, 32'd0);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        push(8'h3C);
        frame("rst3c", 5, 1'b0, -1);

        // Reset values under random inputs
        @(negedge sys_clk);
        rst_n    = 1'b0;
        force_in = 1'b1;
        b_rd = 0; b_tx = 0; b_busy = 0; b_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            EN          = 1'($urandom);
            force_empty = 1'($urandom);
            force_data  = 8'($urandom);
            @(posedge sys_clk);
            #1;
            if (tx !== 1'b1) b_tx++;
            if (fifo_rd !== 1'b0) b_rd++;
            if (busy !== 1'b0) b_busy++;
            if (byte_done !== 1'b0) b_done++;
        end
        chk("rsthold_tx", b_tx, 32'd0);
        chk("rsthold_rd", b_rd, 32'd0);
        chk("rsthold_busy", b_busy, 32'd0);
        chk("rsthold_done", b_done, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain side of the design's byte FIFO: pops words from a `fifo_buffer` instance whenever it is non-empty and serializes each word as an 8N1 UART frame on the Basys3 TX pin. It owns the FIFO `rd` strobe, accounts for the FIFO's one-cycle registered read latency, and reports busy/frame-done status to the surrounding logic.

## Interface
- `CLK_HZ`, 100_000_000: sys_clk frequency in Hz.
- `BAUD`, 115200: line rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (integer divide, must be ≥ 2; 868 at defaults).
- `WIDTH`, 8: data bits per frame; must match the FIFO word width.
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `EN`  in  1  start enable; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO EMPTY flag.
- `fifo_data`  in  WIDTH  FIFO `data_o`; valid the cycle after the FIFO samples `rd`.
- `fifo_rd`  out  1  registered one-cycle read strobe to the FIFO `rd`.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high from the `fifo_rd` cycle until return to IDLE.
- `byte_done`  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- States: IDLE, RDWAIT, LOAD, START, DATA, STOP.
- IDLE: `tx`=1. If `EN` && !`fifo_empty`, register `fifo_rd`=1, set `busy`=1, go to RDWAIT. Otherwise stay.
- RDWAIT: `fifo_rd`=0 (strobe is exactly one cycle). The FIFO samples `rd` on this edge. Go to LOAD.
- LOAD: capture `fifo_data` into the shift register, drive `tx`=0, clear the baud counter, go to START.
- START: hold `tx`=0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA with the bit index at 0.
- DATA: LSB first. Each bit is held CLKS_PER_BIT cycles. After bit WIDTH-1, drive `tx`=1 and go to STOP.
- STOP: hold `tx`=1 for CLKS_PER_BIT cycles. On the final cycle, pulse `byte_done`=1, clear `busy`, and go to IDLE.
- Baud counter: `$clog2(CLKS_PER_BIT)` bits. Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is never free-running outside START/DATA/STOP.
- Bit index: `$clog2(WIDTH)` bits. Wraps to 0 when leaving DATA.
- `tx` is driven from a register, so there are no combinational glitches on the pin.
- EN low mid-frame: the current frame completes, and no new read is issued.
- `fifo_empty` going high mid-frame has no effect. The block never issues `fifo_rd` while `fifo_empty`=1 in IDLE.
- Reset (asynchronous, any state): state=IDLE, `tx`=1, `fifo_rd`=0, `busy`=0, `byte_done`=0, counters=0. A partially sent byte is lost; the FIFO word is already consumed.
- Reset values of all outputs: `tx`=1, `fifo_rd`=0, `busy`=0, `byte_done`=0.

## Timing
- Edge k: IDLE sees the start condition, so `fifo_rd`=1.
- Edge k+1: the FIFO loads `data_o` and `fifo_rd` returns to 0.
- Edge k+2: LOAD latches data and `tx` falls. Latency from the start condition to the start bit is 2 cycles.
- Frame length: (WIDTH+2)·CLKS_PER_BIT cycles from the `tx` falling edge to the `byte_done` edge.
- Back-to-back words: stop bit plus exactly 3 extra idle-high cycles (IDLE, RDWAIT, LOAD) before the next start bit.
- `byte_done` and the IDLE transition coincide. The next `fifo_rd` can assert on the following edge.
- At most one `fifo_rd` per frame; there are never two strobes within (WIDTH+2)·CLKS_PER_BIT cycles.

## Test plan
Bench parameters: CLK_HZ=1_000_000, BAUD=100_000 (10 cycles/bit), with a `fifo_buffer` model attached.

- **Single byte:** preload 8'hA5, EN=1.
  - One `fifo_rd` pulse.
  - `tx` low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles.
  - `byte_done` pulses once, at 102 cycles after `fifo_rd`.
  - `busy` drops with it.
- **Burst:** preload 8'h00, 8'hFF, 8'h55.
  - Three frames in order.
  - Idle-high gap between frames is exactly 13 cycles.
  - FIFO EMPTY after the third `fifo_rd`.
  - No `fifo_rd` while EMPTY=1.
- **Enable gating:** preload two bytes, EN=1, drop EN during bit 3 of frame 1.
  - Frame 1 completes intact.
  - No second `fifo_rd` until EN returns high.
  - Frame 2 then starts within 2 cycles.
- **Empty idle:** EN=1 with the FIFO empty for 1000 cycles.
  - `fifo_rd`=0, `tx`=1, `busy`=0 throughout.
- **Reset mid-frame:** assert `rst_n`=0 asynchronously (between edges) during bit 5.
  - `tx`=1 and `busy`=0 immediately, without waiting for a clock.
  - After release with 8'h3C queued, the next frame is a clean, complete 8'h3C.
- **Reset values:** hold `rst_n`=0 with random inputs.
  - Outputs stay at `tx`=1, `fifo_rd`=0, `busy`=0, `byte_done`=0.
